// File: rtl/max7219_daisy_ctrl.sv
// max7219_daisy_ctrl: serial driver for a daisy chain of MAX7219 matrix drivers
// with single-frame writes and a built-in 14-frame power-up init sequence.
module max7219_daisy_ctrl #(
  parameter int G_NB_MATRIX = 8,
  parameter int G_CLK_DIV   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [3:0]               i_addr,
  input  logic [8*G_NB_MATRIX-1:0] i_data,
  input  logic                     i_init,
  input  logic [3:0]               i_intensity,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_init_done,
  output logic                     o_max7219_clk,
  output logic                     o_max7219_din,
  output logic                     o_max7219_load
);
  localparam int C_NB_BITS = 16 * G_NB_MATRIX;
  localparam int C_BW = C_NB_BITS > 1 ? $clog2(C_NB_BITS) : 1;
  localparam int C_DW = G_CLK_DIV > 1 ? $clog2(G_CLK_DIV) : 1;
  localparam logic [3:0] C_LAST = 4'd13;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, GAP} t_state;
  t_state               r_state, w_next;
  logic [C_NB_BITS-1:0] r_shift;
  logic [C_BW-1:0]      r_bit;
  logic [C_DW-1:0]      r_div;
  logic [3:0]           r_idx;
  logic [3:0]           r_intensity;
  logic                 r_init;
  logic                 w_div_last;
  logic                 w_bit_last;
  logic                 w_init_more;

  // Word for the last matrix in the chain sits in the top bits so it leaves first.
  function automatic logic [C_NB_BITS-1:0] f_frame(input logic [3:0] addr,
                                                   input logic [8*G_NB_MATRIX-1:0] data);
    f_frame = '0;
    for (int k = 0; k < G_NB_MATRIX; k++) f_frame[16*k +: 16] = {4'h0, addr, data[8*k +: 8]};
  endfunction

  function automatic logic [C_NB_BITS-1:0] f_init_frame(input logic [3:0] idx,
                                                        input logic [3:0] intensity);
    logic [3:0] a;
    logic [7:0] d;
    a = idx == 4'd0 ? 4'hC : idx == 4'd1 ? 4'hF : idx == 4'd2 ? 4'h9 :
        idx == 4'd3 ? 4'hB : idx == 4'd4 ? 4'hA : idx == C_LAST ? 4'hC : idx - 4'd4;
    d = idx == 4'd3 ? 8'h07 : idx == 4'd4 ? {4'h0, intensity} : idx == C_LAST ? 8'h01 : 8'h00;
    f_init_frame = f_frame(a, {G_NB_MATRIX{d}});
  endfunction

  assign w_div_last  = r_div == C_DW'(G_CLK_DIV - 1);
  assign w_bit_last  = r_bit == C_BW'(C_NB_BITS - 1);
  assign w_init_more = r_init && r_idx != C_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (i_init || i_start) ? SHIFT_LO : IDLE;
      SHIFT_LO: w_next = w_div_last ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: w_next = !w_div_last ? SHIFT_HI : w_bit_last ? LOAD : SHIFT_LO;
      LOAD:     w_next = w_div_last ? GAP : LOAD;
      GAP:      w_next = !w_div_last ? GAP : w_init_more ? SHIFT_LO : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy         = r_state != IDLE;
    o_max7219_clk  = r_state == SHIFT_HI;
    o_max7219_din  = (r_state == SHIFT_LO || r_state == SHIFT_HI) && r_shift[C_NB_BITS-1];
    o_max7219_load = r_state == LOAD;
    o_done         = r_state == GAP && w_div_last && !r_init;
    o_init_done    = r_state == GAP && w_div_last && r_init && r_idx == C_LAST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit       <= '0;
      r_div       <= '0;
      r_idx       <= '0;
      r_intensity <= '0;
      r_init      <= 1'b0;
    end else begin
      r_div <= (r_state == IDLE || w_div_last) ? '0 : r_div + 1'b1;
      if (r_state == IDLE && i_init) begin
        r_init      <= 1'b1;
        r_idx       <= '0;
        r_intensity <= i_intensity;
        r_shift     <= f_init_frame(4'd0, i_intensity);
        r_bit       <= '0;
      end else if (r_state == IDLE && i_start) begin
        r_init  <= 1'b0;
        r_shift <= f_frame(i_addr, i_data);
        r_bit   <= '0;
      end else if (r_state == SHIFT_HI && w_div_last && !w_bit_last) begin
        r_shift <= r_shift << 1;
        r_bit   <= r_bit + 1'b1;
      end else if (r_state == GAP && w_div_last && w_init_more) begin
        r_idx   <= r_idx + 4'd1;
        r_shift <= f_init_frame(r_idx + 4'd1, r_intensity);
        r_bit   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_max7219_daisy_ctrl.sv
// tb_max7219_daisy_ctrl: scoreboard bench with a behavioural MAX7219 chain model
// capturing the serial stream and latching registers on each load pulse.
module tb_max7219_daisy_ctrl;
  localparam int N = 2;
  localparam int D = 2;
  localparam int FRAME_CYC = (32 * N + 2) * D;
  logic clk = 0;
  logic rst_n, i_start, i_init;
  logic [3:0] i_addr, i_intensity;
  logic [8*N-1:0] i_data;
  logic o_busy, o_done, o_init_done, o_max7219_clk, o_max7219_din, o_max7219_load;
  int checks = 0, errors = 0;
  int edges = 0, loads = 0, dones = 0, init_dones = 0;
  int nbit = 0, load_w = 0, busy_cyc = 0;
  logic p_clk = 0, p_load = 0;
  logic [31:0] sh = '0, expf;
  logic [31:0] sbq[$];
  logic [7:0] regs[N][16];
  logic [3:0] init_a[14] = '{4'hC, 4'hF, 4'h9, 4'hB, 4'hA, 4'h1, 4'h2, 4'h3,
                             4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC};

  max7219_daisy_ctrl #(.G_NB_MATRIX(N), .G_CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_addr(i_addr), .i_data(i_data),
    .i_init(i_init), .i_intensity(i_intensity), .o_busy(o_busy), .o_done(o_done),
    .o_init_done(o_init_done), .o_max7219_clk(o_max7219_clk),
    .o_max7219_din(o_max7219_din), .o_max7219_load(o_max7219_load));

  always #5 clk = ~clk;

  function automatic logic [31:0] frm(input logic [3:0] a, input logic [15:0] d);
    return {4'h0, a, d[15:8], 4'h0, a, d[7:0]};
  endfunction

  task tick;
    @(posedge clk);
    #2;
  endtask

  // Chain model: first-sent word travels through to the last matrix.
  always @(negedge clk) begin
    if (!rst_n) begin
      nbit = 0;
      load_w = 0;
      busy_cyc = 0;
    end else begin
      if (o_max7219_clk && !p_clk) begin
        sh = {sh[30:0], o_max7219_din};
        edges++;
        nbit++;
      end
      if (o_max7219_load) load_w++;
      if (o_max7219_load && !p_load) begin
        loads++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got %h bits %0d", sh, nbit);
        end else begin
          expf = sbq.pop_front();
          if (sh !== expf || nbit != 32) begin
            errors++;
            $display("FAIL frame got %h bits %0d want %h bits 32", sh, nbit, expf);
          end
        end
        for (int k = 0; k < N; k++) regs[k][sh[16*k+8 +: 4]] = sh[16*k +: 8];
        nbit = 0;
      end
      if (!o_max7219_load && p_load) begin
        checks++;
        if (load_w != D) begin
          errors++;
          $display("FAIL load_width got %0d want %0d", load_w, D);
        end
        load_w = 0;
      end
      if (o_busy) busy_cyc++;
      if (o_done) begin
        dones++;
        checks++;
        if (busy_cyc != FRAME_CYC) begin
          errors++;
          $display("FAIL done_latency got %0d want %0d", busy_cyc, FRAME_CYC);
        end
      end
      if (!o_busy) busy_cyc = 0;
      if (o_init_done) init_dones++;
    end
    p_clk = o_max7219_clk;
    p_load = o_max7219_load;
  end

  task test_reset;
    rst_n = 0;
    i_start = 1;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if ({o_busy, o_done, o_init_done, o_max7219_clk, o_max7219_din, o_max7219_load} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b%b%b%b%b%b want 000000", c, o_busy, o_done,
                 o_init_done, o_max7219_clk, o_max7219_din, o_max7219_load);
      end
    end
    checks++;
    if (edges != 0) begin
      errors++;
      $display("FAIL reset_edges got %0d want 0", edges);
    end
    i_start = 0;
    rst_n = 1;
    tick;
  endtask

  task run_frame(input logic [3:0] a, input logic [15:0] d, input string nm);
    int d0, e0, n;
    d0 = dones;
    e0 = edges;
    sbq.push_back(frm(a, d));
    i_addr = a;
    i_data = d;
    i_start = 1;
    tick;
    i_start = 0;
    n = 0;
    while (dones == d0 && n < 400) begin
      tick;
      n++;
    end
    repeat (4) tick;
    checks++;
    if (dones != d0 + 1) begin
      errors++;
      $display("FAIL %s_done got %0d want %0d", nm, dones - d0, 1);
    end
    checks++;
    if (edges - e0 != 32) begin
      errors++;
      $display("FAIL %s_edges got %0d want 32", nm, edges - e0);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (regs[k][a] !== d[8*k +: 8]) begin
        errors++;
        $display("FAIL %s_reg m%0d got %h want %h", nm, k, regs[k][a], d[8*k +: 8]);
      end
    end
  endtask

  task test_single;
    int l0;
    l0 = loads;
    run_frame(4'h3, 16'hA55A, "single");
    checks++;
    if (loads - l0 != 1) begin
      errors++;
      $display("FAIL single_loads got %0d want 1", loads - l0);
    end
  endtask

  task test_busy_reject;
    int d0, e0, n;
    d0 = dones;
    e0 = edges;
    sbq.push_back(frm(4'h7, 16'h0F0F));
    i_addr = 4'h7;
    i_data = 16'h0F0F;
    i_start = 1;
    tick;
    i_start = 0;
    repeat (9) tick;
    i_data = 16'hFFFF;
    i_start = 1;
    tick;
    i_start = 0;
    n = 0;
    while (dones == d0 && n < 400) begin
      tick;
      n++;
    end
    repeat (40) tick;
    checks++;
    if (dones - d0 != 1) begin
      errors++;
      $display("FAIL reject_done got %0d want 1", dones - d0);
    end
    checks++;
    if (edges - e0 != 32) begin
      errors++;
      $display("FAIL reject_edges got %0d want 32", edges - e0);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_busy got %b want 0", o_busy);
    end
  endtask

  task run_init(input logic [3:0] inten, input logic also_start, input string nm);
    int i0, d0, l0, n, gaps;
    logic [7:0] dv;
    i0 = init_dones;
    d0 = dones;
    l0 = loads;
    gaps = 0;
    for (int i = 0; i < 14; i++) begin
      dv = i == 3 ? 8'h07 : i == 4 ? {4'h0, inten} : i == 13 ? 8'h01 : 8'h00;
      sbq.push_back(frm(init_a[i], {dv, dv}));
    end
    i_intensity = inten;
    i_addr = 4'h5;
    i_data = 16'h7777;
    i_init = 1;
    i_start = also_start;
    tick;
    i_init = 0;
    i_start = 0;
    n = 0;
    while (init_dones == i0 && n < 3000) begin
      tick;
      n++;
      if (init_dones == i0 && !o_busy) gaps++;
    end
    repeat (4) tick;
    checks++;
    if (init_dones - i0 != 1) begin
      errors++;
      $display("FAIL %s_init_done got %0d want 1", nm, init_dones - i0);
    end
    checks++;
    if (dones != d0) begin
      errors++;
      $display("FAIL %s_no_done got %0d want 0", nm, dones - d0);
    end
    checks++;
    if (loads - l0 != 14) begin
      errors++;
      $display("FAIL %s_loads got %0d want 14", nm, loads - l0);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL %s_busy_gaps got %0d want 0", nm, gaps);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (regs[k][4'hA] !== {4'h0, inten} || regs[k][4'hB] !== 8'h07 || regs[k][4'hC] !== 8'h01 ||
          regs[k][4'hF] !== 8'h00 || regs[k][4'h9] !== 8'h00) begin
        errors++;
        $display("FAIL %s_ctrl_regs m%0d got A=%h B=%h C=%h F=%h 9=%h want A=%h B=07 C=01 F=00 9=00",
                 nm, k, regs[k][4'hA], regs[k][4'hB], regs[k][4'hC], regs[k][4'hF], regs[k][4'h9],
                 {4'h0, inten});
      end
      for (int a = 1; a <= 8; a++) begin
        checks++;
        if (regs[k][a] !== 8'h00) begin
          errors++;
          $display("FAIL %s_digit m%0d d%0d got %h want 00", nm, k, a, regs[k][a]);
        end
      end
    end
  endtask

  task test_init;
    run_init(4'h9, 1'b0, "init");
  endtask

  task test_priority;
    run_init(4'h4, 1'b1, "priority");
  endtask

  task test_abort;
    int e0, l0, n;
    e0 = edges;
    sbq.push_back(frm(4'h2, 16'hBEEF));
    i_addr = 4'h2;
    i_data = 16'hBEEF;
    i_start = 1;
    tick;
    i_start = 0;
    n = 0;
    while (edges - e0 < 21 && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (edges - e0 != 21 || o_max7219_clk !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach edges %0d clk %b want 21 1", edges - e0, o_max7219_clk);
    end
    l0 = loads;
    rst_n = 0;
    tick;
    checks++;
    if ({o_busy, o_done, o_init_done, o_max7219_clk, o_max7219_din, o_max7219_load} !== 6'b0) begin
      errors++;
      $display("FAIL abort_outputs got %b%b%b%b%b%b want 000000", o_busy, o_done, o_init_done,
               o_max7219_clk, o_max7219_din, o_max7219_load);
    end
    tick;
    rst_n = 1;
    sbq.delete();
    repeat (10) tick;
    checks++;
    if (loads != l0) begin
      errors++;
      $display("FAIL abort_load got %0d want %0d", loads, l0);
    end
    run_frame(4'h4, 16'h1234, "resume");
  endtask

  initial begin
    rst_n = 0;
    i_start = 1;
    i_init = 0;
    i_addr = '0;
    i_data = '0;
    i_intensity = '0;
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 16; a++) regs[k][a] = 8'hEE;
    test_reset;
    test_single;
    test_busy_reject;
    test_init;
    test_priority;
    test_abort;
    tick;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
